// File: rtl/vector_alu_seq.sv
// Sequential SIMD ALU: per-lane ADD/SUB/MOV in one EXEC cycle, MUL by iterative shift-add over N cycles.
// busy/done/result are taken straight from flops so they are stable for a falling-edge sampler downstream.
module vector_alu_seq #(
   parameter int N     = 16,
   parameter int LANES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [N*LANES-1:0]   a,
   input  logic [N*LANES-1:0]   b,
   output logic                 busy,
   output logic                 done,
   output logic [N*LANES-1:0]   result
);

   localparam int W     = N * LANES;
   localparam int CNT_W = $clog2(N) + 1;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;

   // One bit per non-idle state so busy/done are single flop bits, never a decode.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t             state, state_nxt;
   logic [W-1:0]       a_q, b_q, acc_q;
   logic [W-1:0]       acc_nxt, a_shl, b_shr;
   logic [1:0]         op_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               last_iter;

   function automatic logic [W-1:0] lane_alu(input logic [1:0]   f,
                                             input logic [W-1:0] x,
                                             input logic [W-1:0] y);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++) begin
         case (f)
            OP_ADD:  r[i*N +: N] = x[i*N +: N] + y[i*N +: N];
            OP_SUB:  r[i*N +: N] = x[i*N +: N] - y[i*N +: N];
            default: r[i*N +: N] = x[i*N +: N];
         endcase
      end
      return r;
   endfunction

   // Shift-add step: a_q holds a<<k, b_q holds b>>k, so bit 0 of b_q is multiplier bit k.
   always_comb begin
      acc_nxt = acc_q;
      a_shl   = a_q;
      b_shr   = b_q;
      for (int i = 0; i < LANES; i++) begin
         acc_nxt[i*N +: N] = acc_q[i*N +: N] + (b_q[i*N] ? a_q[i*N +: N] : {N{1'b0}});
         a_shl[i*N +: N]   = a_q[i*N +: N] << 1;
         b_shr[i*N +: N]   = b_q[i*N +: N] >> 1;
      end
   end

   assign last_iter = (cnt_q == CNT_W'(N - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = EXEC;
         EXEC:    if (op_q != OP_MUL || last_iter) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = state[0];
      done = state[1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         result <= '0;
      end else if (state == IDLE && start) begin
         a_q   <= a;
         b_q   <= b;
         op_q  <= op;
         acc_q <= '0;
         cnt_q <= '0;
      end else if (state == EXEC) begin
         if (op_q != OP_MUL) begin
            result <= lane_alu(op_q, a_q, b_q);
         end else if (last_iter) begin
            result <= acc_nxt;
         end else begin
            acc_q <= acc_nxt;
            a_q   <= a_shl;
            b_q   <= b_shr;
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_vector_alu_seq.sv
// Scoreboard bench for vector_alu_seq: the driver predicts accept edges and results, the monitor checks on done.
module tb_vector_alu_seq;

   localparam int N     = 16;
   localparam int LANES = 4;
   localparam int W     = N * LANES;

   logic          clk, rst, start, busy, done;
   logic [1:0]    op;
   logic [W-1:0]  a, b, result;

   typedef struct {
      logic [W-1:0] res;
      int           cyc;
      int           blen;
   } exp_t;

   exp_t          sbq[$];
   int            cyc      = 0;
   int            free_cyc = 0;
   int            last_t   = 0;
   int            vecs     = 0;
   int            errs     = 0;
   int            run      = 0;
   logic [W-1:0]  hold     = '0;
   bit            fin      = 0;

   vector_alu_seq #(.N(N), .LANES(LANES)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] model(input logic [1:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0]    res;
      longint unsigned mod, xa, ya, r;
      mod = longint'(1) << N;
      res = '0;
      for (int i = 0; i < LANES; i++) begin
         xa = longint'(x[i*N +: N]);
         ya = longint'(y[i*N +: N]);
         case (f)
            2'd0:    r = (xa + ya) % mod;
            2'd1:    r = (xa + mod - ya) % mod;
            2'd2:    r = (xa * ya) % mod;
            default: r = xa;
         endcase
         res[i*N +: N] = r[N-1:0];
      end
      return res;
   endfunction

   function automatic logic [W-1:0] rnd();
      return {$urandom, $urandom};
   endfunction

   // Called between a falling edge and the next rising edge (edge number cyc+1).
   task automatic arm(input logic s, input logic [1:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic use_exp, input logic [W-1:0] ex);
      start = s;
      op    = f;
      a     = x;
      b     = y;
      if (s && (cyc + 1 >= free_cyc)) begin
         int lat;
         lat    = (f == 2'd2) ? N : 1;
         last_t = cyc + 1;
         sbq.push_back('{use_exp ? ex : model(f, x, y), last_t + lat, lat});
         free_cyc = last_t + lat + 2;
      end
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      arm(1'b0, 2'($urandom), rnd(), rnd(), 1'b0, '0);
   endtask

   task automatic issue(input logic [1:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic use_exp, input logic [W-1:0] ex);
      @(negedge clk);
      for (int k = 0; k < 200 && (cyc + 1 < free_cyc); k++) begin
         arm(1'b0, 2'($urandom), rnd(), rnd(), 1'b0, '0);
         @(negedge clk);
      end
      arm(1'b1, f, x, y, use_exp, ex);
   endtask

   // Monitor / checker
   initial begin
      exp_t e;
      #2;
      forever begin
         @(negedge clk or negedge rst);
         if (rst === 1'b0) begin
            hold = '0;
            run  = 0;
            #1;
            vecs += 3;
            if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b expected 0", busy); end
            if (done !== 1'b0) begin errs++; $display("FAIL rst_done: got %b expected 0", done); end
            if (result !== '0) begin errs++; $display("FAIL rst_result: got %h expected 0", result); end
         end else begin
            if (busy === 1'b1 && done === 1'b1) begin
               errs++;
               $display("FAIL busy_done_overlap at cycle %0d: got both 1 expected exclusive", cyc);
            end
            if (done === 1'b1) begin
               if (sbq.size() == 0) begin
                  errs++;
                  $display("FAIL unexpected_done at cycle %0d: got done=1 expected 0", cyc);
               end else begin
                  e = sbq.pop_front();
                  vecs += 3;
                  if (result !== e.res) begin
                     errs++;
                     $display("FAIL result at cycle %0d: got %h expected %h", cyc, result, e.res);
                  end
                  if (cyc != e.cyc) begin
                     errs++;
                     $display("FAIL done_time: got cycle %0d expected cycle %0d", cyc, e.cyc);
                  end
                  if (run != e.blen) begin
                     errs++;
                     $display("FAIL busy_len at cycle %0d: got %0d expected %0d", cyc, run, e.blen);
                  end
                  hold = e.res;
               end
               run = 0;
            end else begin
               if (busy === 1'b1) run++;
               if (result !== hold) begin
                  errs++;
                  $display("FAIL result_hold at cycle %0d: got %h expected %h", cyc, result, hold);
               end
            end
            if (fin) begin
               vecs++;
               if (sbq.size() != 0) begin
                  errs++;
                  $display("FAIL drain: got %0d pending expected 0", sbq.size());
               end
               $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
               $finish;
            end
         end
      end
   end

   // Stimulus
   initial begin
      rst   = 1'b1;
      start = 1'b0;
      op    = 2'd0;
      a     = '0;
      b     = '0;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      // First edge after release must accept.
      arm(1'b1, 2'd0, 64'h0004_0003_0002_FFFF, 64'h0001_0001_0001_0001, 1'b1, 64'h0005_0004_0003_0000);
      issue(2'd1, 64'h0, 64'h0001_0001_0001_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      issue(2'd2, {16'd3, 16'h0100, 16'hFFFF, 16'd0}, {16'd5, 16'h0100, 16'd2, 16'd7},
            1'b1, {16'd15, 16'h0000, 16'hFFFE, 16'd0});
      issue(2'd3, 64'h1234_5678_9ABC_DEF0, rnd(), 1'b1, 64'h1234_5678_9ABC_DEF0);
      issue(2'd2, rnd(), rnd(), 1'b0, '0);

      // start held high, operands changing every cycle
      for (int k = 0; k < 200 && (cyc + 1 < free_cyc); k++) idle_cycle();
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         arm(1'b1, 2'd0, rnd(), rnd(), 1'b0, '0);
      end

      // abort a MUL at iteration 7 with a between-edge reset pulse
      issue(2'd2, rnd(), rnd(), 1'b0, '0);
      while (cyc < last_t + 7) idle_cycle();
      #1 rst = 1'b0;
      #2 rst = 1'b1;
      sbq.delete();
      free_cyc = 0;
      arm(1'b1, 2'd0, rnd(), rnd(), 1'b0, '0);

      for (int k = 0; k < 40; k++) begin
         issue(2'($urandom), rnd(), rnd(), 1'b0, '0);
         repeat ($urandom_range(0, 3)) idle_cycle();
      end

      for (int k = 0; k < 200 && sbq.size() != 0; k++) idle_cycle();
      fin = 1;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/vector_alu_seq.md
VECTOR_ALU_SEQ -- requirements
Module: vector_alu_seq

Interface
REQ-001 Parameter N, default 16, lane width in bits; the result drives an N*LANES-wide register_en data input.
REQ-002 Parameter LANES, default 4, number of independent SIMD lanes.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low (rst=0 resets).
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  2  00 ADD, 01 SUB, 10 MUL, 11 MOV (pass a).
REQ-007 a  input  N*LANES  operand A; lane i at bits [i*N +: N].
REQ-008 b  input  N*LANES  operand B; same lane packing.
REQ-009 busy  output  1  high while in EXEC.
REQ-010 done  output  1  one-cycle pulse marking result valid; wired to the downstream register_en enable.
REQ-011 result  output  N*LANES  lane-packed result; held stable between done pulses.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, EXEC, DONE.
REQ-013 In IDLE, a rising edge with start=1 SHALL capture a, b and op into internal registers and enter EXEC; start=0 stays in IDLE.
REQ-014 start SHALL be ignored in EXEC and DONE; operand changes after capture SHALL NOT affect the in-flight operation.
REQ-015 ADD, SUB and MOV SHALL spend exactly 1 cycle in EXEC; MUL SHALL spend exactly N cycles in EXEC.
REQ-016 From the accepting edge t, done SHALL rise after edge t+1 (ADD/SUB/MOV) or after edge t+N (MUL).
REQ-017 DONE SHALL last exactly one cycle, then return unconditionally to IDLE; minimum issue interval is 3 cycles for ADD/SUB/MOV and N+2 cycles for MUL.
REQ-018 busy SHALL be 1 only in EXEC; done SHALL be 1 only in DONE; busy and done SHALL never both be 1.
REQ-019 ADD/SUB SHALL be per-lane modulo 2^N; carry and borrow SHALL never propagate between lanes; no overflow flag.
REQ-020 MUL SHALL compute per lane the low N bits of the unsigned product a*b.
REQ-021 MUL SHALL use an iterative shift-add implementation: one multiplier bit per EXEC cycle, all lanes in parallel, with a shared iteration counter of ceil(log2(N))+1 bits running from 0 to N-1.
REQ-022 MOV SHALL pass the captured a unchanged to result; b is ignored.
REQ-023 result SHALL be updated only on the edge entering DONE.
REQ-024 result SHALL hold its value through DONE, IDLE and the whole next EXEC, until the next edge entering DONE.
REQ-025 Because register_en samples on the falling edge, result and done SHALL come directly from flops with no combinational path from inputs, so they are stable at the mid-cycle falling edge.

Reset
REQ-026 rst=0 SHALL immediately, without waiting for clk, force: state IDLE, busy=0, done=0, result=0, iteration counter=0, captured operands=0.
REQ-027 Reset asserted mid-EXEC SHALL abort the operation; no done pulse SHALL be produced for it after release.
REQ-028 After release (rst=1), the first rising edge SHALL be treated as an IDLE edge; start=1 on that edge SHALL be accepted.

Verification
REQ-029 The bench SHALL cover ADD with a=0x0004_0003_0002_FFFF, b=0x0001_0001_0001_0001 -> done 1 cycle wide after edge t+1, result=0x0005_0004_0003_0000, lane0 wrap with no carry into lane1.
REQ-030 The bench SHALL cover SUB with a=0, b=0x0001_0001_0001_0001 -> result=0xFFFF_FFFF_FFFF_FFFF, no cross-lane borrow.
REQ-031 The bench SHALL cover MUL with lanes a=(3,0x0100,0xFFFF,0), b=(5,0x0100,2,7) -> busy exactly 16 cycles, done after edge t+16, result lanes=(15,0x0000,0xFFFE,0).
REQ-032 The bench SHALL cover start held high continuously with a and b changing every cycle -> one operation every 3 cycles (ADD), each using the operands captured at its accept edge, no accept during EXEC/DONE.
REQ-033 The bench SHALL cover rst=0 pulsed between clock edges at MUL iteration 7 -> busy, done and result go 0 asynchronously, no done after release, and a new ADD issued on the first edge after release completes correctly.
REQ-034 The bench SHALL cover result from a completed MOV (a=0x1234_5678_9ABC_DEF0) staying unchanged through a following 16-cycle MUL until that MUL's done edge.
